// File: rtl/in2out_fifo.sv
// Push-to-pull adapter: PipeIn enq stream into a circular buffer read as PipeOut first/deq.
// Ready outputs come only from registered occupancy, so ENA inputs never reach any ready.
module in2out_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_enq_ena_i,
  input  logic [Width-1:0] in_enq_v_i,
  output logic             in_enq_rdy_o,
  output logic [Width-1:0] out_first_o,
  output logic             out_first_rdy_o,
  input  logic             out_deq_ena_i,
  output logic             out_deq_rdy_o,
  output logic [Aw:0]      count_o,
  output logic             err_o
);

  localparam logic [Aw:0] FullCount = Depth[Aw:0];

  logic [Width-1:0] mem [Depth];

  logic [Aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [Aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Aw:0]   count_q, count_d;
  logic          err_q, err_d;

  logic enq_rdy;
  logic deq_rdy;
  logic do_enq;
  logic do_deq;

  assign enq_rdy = (count_q != FullCount);
  assign deq_rdy = (count_q != '0);
  assign do_enq  = in_enq_ena_i && enq_rdy;
  assign do_deq  = out_deq_ena_i && deq_rdy;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (do_enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Strobing a side that is not ready is a producer/consumer bug; latch it until reset.
    if ((in_enq_ena_i && !enq_rdy) || (out_deq_ena_i && !deq_rdy)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is never cleared; reset only gates off a write issued in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_enq) begin
      mem[wr_ptr_q] <= in_enq_v_i;
    end
  end

  assign in_enq_rdy_o    = enq_rdy;
  assign out_first_o     = mem[rd_ptr_q];
  assign out_first_rdy_o = deq_rdy;
  assign out_deq_rdy_o   = deq_rdy;
  assign count_o         = count_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_in2out_fifo.sv
// Directed bench for in2out_fifo (Width=32, Depth=4) with immediate-assertion checks.
module tb_in2out_fifo;

  logic        clk;
  logic        nrst;
  logic        enq;
  logic [31:0] enq_v;
  logic        enq_rdy;
  logic [31:0] first;
  logic        first_rdy;
  logic        deq;
  logic        deq_rdy;
  logic [2:0]  count;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  bit inv_on   = 0;

  in2out_fifo #(
    .Width(32),
    .Depth(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (nrst),
    .in_enq_ena_i   (enq),
    .in_enq_v_i     (enq_v),
    .in_enq_rdy_o   (enq_rdy),
    .out_first_o    (first),
    .out_first_rdy_o(first_rdy),
    .out_deq_ena_i  (deq),
    .out_deq_rdy_o  (deq_rdy),
    .count_o        (count),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Occupancy bound and ready consistency on every cycle once out of the initial X state.
  always @(negedge clk) begin
    if (inv_on) begin
      n_checks++;
      assert (count <= 3'd4 && deq_rdy === first_rdy && enq_rdy === (count != 3'd4))
      else begin
        n_fail++;
        $error("FAIL invariant: count %0d deq_rdy %b first_rdy %b enq_rdy %b",
               count, deq_rdy, first_rdy, enq_rdy);
      end
    end
  end

  task automatic push(input logic [31:0] v);
    enq   = 1'b1;
    enq_v = v;
    step();
    enq   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, first, exp);
    deq = 1'b1;
    step();
    deq = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
  endtask

  initial begin
    nrst  = 1'b0;
    enq   = 1'b1;
    deq   = 1'b1;
    enq_v = 32'h1234_5678;

    // Reset with strobes toggling
    step();
    enq = 1'b0;
    deq = 1'b1;
    step();
    inv_on = 1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    check("rst_first_rdy", {31'd0, first_rdy}, 32'd0);
    check("rst_deq_rdy", {31'd0, deq_rdy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    nrst = 1'b1;
    deq  = 1'b0;
    step();
    check("idle_count", {29'd0, count}, 32'd0);

    // Single transfer
    push(32'hDEAD_BEEF);
    check("single_first", first, 32'hDEAD_BEEF);
    check("single_first_rdy", {31'd0, first_rdy}, 32'd1);
    check("single_count", {29'd0, count}, 32'd1);
    pop_check("single_pop", 32'hDEAD_BEEF);
    check("single_count_after", {29'd0, count}, 32'd0);
    check("single_first_rdy_after", {31'd0, first_rdy}, 32'd0);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) push(i);
    check("full_count", {29'd0, count}, 32'd4);
    check("full_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    check("full_err_clear", {31'd0, err}, 32'd0);
    push(32'd5);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_count", {29'd0, count}, 32'd4);
    for (int i = 1; i <= 4; i++) pop_check("drain", i);
    check("drain_count", {29'd0, count}, 32'd0);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // Underflow attempt
    deq = 1'b1;
    step();
    deq = 1'b0;
    check("udf_err", {31'd0, err}, 32'd1);
    check("udf_count", {29'd0, count}, 32'd0);
    do_reset();

    // Wrap-around: 10 rounds of 3 in / 3 out
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 3; j++) push(r * 3 + j);
      for (int j = 0; j < 3; j++) pop_check("wrap", r * 3 + j);
    end
    check("wrap_count", {29'd0, count}, 32'd0);
    check("wrap_err", {31'd0, err}, 32'd0);

    // Simultaneous enq+deq at count=2
    push(32'd100);
    push(32'd101);
    for (int k = 0; k < 8; k++) begin
      check("simul_first", first, 100 + k);
      enq   = 1'b1;
      enq_v = 102 + k;
      deq   = 1'b1;
      step();
      enq   = 1'b0;
      deq   = 1'b0;
      check("simul_count", {29'd0, count}, 32'd2);
    end
    check("simul_head", first, 32'd108);

    // Full with both strobes: enq blocked, deq accepted
    push(32'd110);
    push(32'd111);
    check("full2_count", {29'd0, count}, 32'd4);
    enq   = 1'b1;
    enq_v = 32'd200;
    deq   = 1'b1;
    step();
    enq   = 1'b0;
    deq   = 1'b0;
    check("full2_count_after", {29'd0, count}, 32'd3);
    check("full2_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    check("full2_err", {31'd0, err}, 32'd1);
    pop_check("full2_drain", 32'd109);
    pop_check("full2_drain", 32'd110);
    pop_check("full2_drain", 32'd111);
    check("full2_empty", {29'd0, count}, 32'd0);
    do_reset();

    // Reset mid-operation with an enqueue strobe
    push(32'd1);
    push(32'd2);
    push(32'd3);
    check("mid_count", {29'd0, count}, 32'd3);
    nrst  = 1'b0;
    enq   = 1'b1;
    enq_v = 32'd77;
    step();
    nrst  = 1'b1;
    enq   = 1'b0;
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_first_rdy", {31'd0, first_rdy}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    push(32'h55);
    check("post_rst_first", first, 32'h55);
    check("post_rst_count", {29'd0, count}, 32'd1);

    inv_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in2out_fifo.md
Name: in2out_fifo

Overview:
- Converts a push-style PipeIn (enq) stream into a pull-style PipeOut (first/deq) stream. It is the reverse of the Out2In copy rule.
- A circular buffer of DEPTH entries decouples the producer, which calls enq, from the consumer, which reads first and calls deq.
- Sits between any PipeIn-driving producer and any PipeOut-consuming block, e.g. ahead of an Out2In stage or a funnel.

Parameters:
- WIDTH, 32, data width of enq$v and first.
- DEPTH, 4, number of entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  synchronous active-low reset, sampled on rising edge of CLK.
- in$enq__ENA  input  1  producer enqueue strobe.
- in$enq$v  input  WIDTH  enqueue data.
- in$enq__RDY  output  1  buffer can accept an entry this cycle.
- out$first  output  WIDTH  head entry data.
- out$first__RDY  output  1  out$first is valid.
- out$deq__ENA  input  1  consumer dequeue strobe.
- out$deq__RDY  output  1  dequeue permitted this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.
- err  output  1  sticky protocol-error flag.

Behaviour:
- State: mem[DEPTH] (no reset), rd_ptr and wr_ptr (AW bits each), count (AW+1 bits), err.
- Reset (nRST==0 at posedge): rd_ptr=0, wr_ptr=0, count=0, err=0. Reset has priority over all strobes in the same cycle.
  - Reset mid-stream discards all contents; mem contents are not cleared.
  - Outputs after reset: in$enq__RDY=1, out$first__RDY=0, out$deq__RDY=0, count=0, err=0. out$first is don't-care while first__RDY=0.
- Ready signals are combinational from registered state only, with no combinational path from ENA inputs:
  - in$enq__RDY = (count != DEPTH)
  - out$first__RDY = out$deq__RDY = (count != 0)
  - out$first = mem[rd_ptr]
- Enqueue takes effect when in$enq__ENA && in$enq__RDY: mem[wr_ptr] <= in$enq$v, wr_ptr <= wr_ptr+1.
- Dequeue takes effect when out$deq__ENA && out$deq__RDY: rd_ptr <= rd_ptr+1.
- Pointers wrap modulo DEPTH through natural AW-bit overflow.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, or on neither.
- Latency: an entry enqueued at cycle N appears on out$first with first__RDY=1 at cycle N+1 (no same-cycle bypass).
- Full (count==DEPTH): enq__RDY=0. A dequeue in that cycle takes effect; enq__RDY rises the next cycle (no pass-through when full).
- Empty (count==0): deq__RDY=0. A simultaneous enqueue fills the buffer; the data is visible next cycle.
- Simultaneous enq and deq when 0<count<DEPTH: both take effect and count holds.
- Protocol violations:
  - enq__ENA while enq__RDY==0: ignored (no write, no pointer move) and err <= 1.
  - deq__ENA while deq__RDY==0: ignored and err <= 1.
  - err stays set until reset.
- count must never exceed DEPTH or underflow; the bench asserts this every cycle.

Test Plan:
- Reset then idle: hold nRST=0 for 2 cycles with strobes toggling -> count=0, enq__RDY=1, first__RDY=0, err=0.
- Single transfer: enq 0xDEADBEEF at cycle 1 -> cycle 2 first=0xDEADBEEF, first__RDY=1, count=1. deq at cycle 2 -> cycle 3 count=0, first__RDY=0.
- Fill/drain with DEPTH=4:
  - Enq 1,2,3,4 on consecutive cycles -> count=4, enq__RDY=0.
  - Attempt enq 5 -> no write, err=1.
  - Deq 4 times -> first reads 1,2,3,4 in order, count=0.
- Wrap-around: 10 rounds of enq 3 / deq 3 (30 values 0..29) -> output order 0..29 exact, count returns to 0, err=0.
- Simultaneous enq+deq at count=2 for 8 cycles -> count stays 2, FIFO order preserved. At count=4 (full): enq blocked, deq accepted -> count=3, enq__RDY=1 next cycle.
- Reset mid-operation: at count=3, assert nRST=0 for 1 cycle together with enq__ENA=1 -> count=0, first__RDY=0. Enq 0x55 afterwards -> first=0x55 next cycle.
